// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Purpose: receives a framed program image over a byte stream and writes it
// into a CPU instruction memory. The CPU is held in reset until a frame with a
// good checksum has been completely written.
//
// Frame: SYNC_BYTE, length byte L, N = L+1 words (high byte first, N capped at
// 2^ADDR_W), then a checksum byte equal to the XOR of all 2N data bytes.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high reset
//   in_data    - byte stream from the host
//   in_valid   - in_data is valid
//   in_ready   - loader accepts a byte this cycle (low only while writing)
//   mem_we     - one-cycle instruction-memory write strobe
//   mem_addr   - instruction word address
//   mem_wdata  - instruction word (opcode in [15:12])
//   cpu_reset  - holds the CPU in reset unless a good program is loaded
//   busy       - a load is in progress
//   done       - last load completed with a good checksum
//   err        - last load failed its checksum
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_CHK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Highest word index the memory can hold; longer frames are truncated to it.
    localparam int MAX_LAST = (1 << ADDR_W) - 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last;
    logic [15:0]       r_wdata;
    logic [7:0]        r_csum;

    logic              w_accept;
    logic              w_is_sync;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_len_last;

    assign w_accept    = in_valid & in_ready;
    assign w_is_sync   = (in_data == SYNC_BYTE);
    assign w_last_word = (r_addr == r_last);
    // The length byte is already N-1, i.e. the index of the last word.
    assign w_len_last  = (32'(in_data) > MAX_LAST) ? ADDR_W'(MAX_LAST)
                                                   : ADDR_W'(in_data);

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_SYNC;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b1;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_reset = 1'b1;
        unique case (r_state)
            ST_SYNC: if (w_accept && w_is_sync) w_next = ST_LEN;
            ST_LEN: begin
                busy = 1'b1;
                if (w_accept) w_next = ST_HI;
            end
            ST_HI: begin
                busy = 1'b1;
                if (w_accept) w_next = ST_LO;
            end
            ST_LO: begin
                busy = 1'b1;
                if (w_accept) w_next = ST_WR;
            end
            ST_WR: begin
                busy     = 1'b1;
                in_ready = 1'b0;
                mem_we   = 1'b1;
                w_next   = w_last_word ? ST_CHK : ST_HI;
            end
            ST_CHK: begin
                busy = 1'b1;
                if (w_accept) w_next = (in_data == r_csum) ? ST_DONE : ST_FAIL;
            end
            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (w_accept && w_is_sync) w_next = ST_LEN;
            end
            ST_FAIL: begin
                err = 1'b1;
                if (w_accept && w_is_sync) w_next = ST_LEN;
            end
            default: w_next = ST_SYNC;
        endcase
    end

    // Datapath: address, word count, data word and running checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_last  <= '0;
            r_wdata <= '0;
            r_csum  <= '0;
        end else begin
            unique case (r_state)
                ST_SYNC, ST_DONE, ST_FAIL: begin
                    if (w_accept && w_is_sync) begin
                        r_addr <= '0;
                        r_csum <= '0;
                    end
                end
                ST_LEN: if (w_accept) r_last <= w_len_last;
                ST_HI: begin
                    if (w_accept) begin
                        r_wdata[15:8] <= in_data;
                        r_csum        <= r_csum ^ in_data;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_wdata[7:0] <= in_data;
                        r_csum       <= r_csum ^ in_data;
                    end
                end
                // The index stops on the last word so mem_addr never passes
                // N-1, which also rules out wrap-around on a full-size image.
                ST_WR: if (!w_last_word) r_addr <= r_addr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
